// File: rtl/mult8_eval_pkg.sv
// Shared definitions for the approximate-multiplier error evaluator:
// state encodings, LFSR polynomial/seed, and accumulator saturation value.
package mult8_eval_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // x^16 + x^14 + x^13 + x^11 + 1, taps on state bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  localparam logic [31:0] SUM_SAT           = 32'hFFFF_FFFF;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mult8_err_eval_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load; a zero seed loads the default
// seed so the register can never lock up.
module lfsr16
  import mult8_eval_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        enable,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= LFSR_DEFAULT_SEED;
    else if (load)
      state <= (seed == '0) ? LFSR_DEFAULT_SEED : seed;
    else if (enable)
      state <= lfsr_next(state);
  end

endmodule

// File: rtl/mult8_err_eval.sv
// Drives operand vectors into an approximate multiplier and accumulates
// error statistics of its product against the exact product.
module mult8_err_eval
  import mult8_eval_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int OUTW    = 16,
  parameter int DUT_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [15:0]      seed,
  input  logic [15:0]      num_vec,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_valid,
  input  logic [OUTW-1:0]  dut_p,
  output logic             busy,
  output logic             done,
  output logic [16:0]      err_cnt,
  output logic [31:0]      sum_abs_err,
  output logic [OUTW-1:0]  max_abs_err
);

  logic [1:0]      state;
  logic            mode_r;
  logic [15:0]     idx;
  logic [15:0]     last_idx;
  logic [15:0]     lfsr_q;
  logic [15:0]     seed_eff;
  logic [15:0]     next_vec;
  logic            accept;
  logic            advance;
  logic [OUTW-1:0] exact_now;
  logic            cmp_valid;
  logic [OUTW-1:0] cmp_exact;
  logic            line_busy;
  logic [OUTW-1:0] abs_err;
  logic [32:0]     sum_next;

  always_comb begin
    accept    = start && (state == ST_IDLE || state == ST_DONE);
    advance   = (state == ST_RUN) && (idx != last_idx);
    seed_eff  = (seed == '0) ? LFSR_DEFAULT_SEED : seed;
    next_vec  = mode_r ? lfsr_next(lfsr_q) : idx + 16'd1;
    exact_now = OUTW'(op_a) * OUTW'(op_b);
  end

  // LFSR state always equals the vector currently on op_a/op_b in random mode
  lfsr16 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .enable (advance && mode_r),
    .seed   (seed),
    .state  (lfsr_q)
  );

  generate
    if (DUT_LAT == 0) begin : g_nolat
      always_comb begin
        cmp_valid = op_valid;
        cmp_exact = exact_now;
        line_busy = 1'b0;
      end
    end else begin : g_lat
      logic [DUT_LAT-1:0] vld;
      logic [OUTW-1:0]    prod [DUT_LAT];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld <= '0;
          for (int unsigned i = 0; i < DUT_LAT; i++) prod[i] <= '0;
        end else begin
          vld[0]  <= op_valid;
          prod[0] <= exact_now;
          for (int unsigned i = 1; i < DUT_LAT; i++) begin
            vld[i]  <= vld[i-1];
            prod[i] <= prod[i-1];
          end
        end
      end

      always_comb begin
        cmp_valid = vld[DUT_LAT-1];
        cmp_exact = prod[DUT_LAT-1];
        line_busy = |vld;
      end
    end
  endgenerate

  always_comb begin
    abs_err  = (dut_p >= cmp_exact) ? dut_p - cmp_exact : cmp_exact - dut_p;
    sum_next = {1'b0, sum_abs_err} + 33'(abs_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      mode_r      <= 1'b0;
      idx         <= '0;
      last_idx    <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_valid    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_cnt     <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
    end else if (accept) begin
      state       <= ST_RUN;
      mode_r      <= mode;
      idx         <= '0;
      last_idx    <= mode ? num_vec - 16'd1 : 16'hFFFF;
      {op_a, op_b} <= mode ? seed_eff : 16'h0000;
      op_valid    <= 1'b1;
      busy        <= 1'b1;
      done        <= 1'b0;
      err_cnt     <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (advance) begin
            idx          <= idx + 16'd1;
            {op_a, op_b} <= next_vec;
          end else begin
            op_valid <= 1'b0;
            state    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // finish only once the last vector has left the latency line
          if (!op_valid && !line_busy) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase

      if (cmp_valid) begin
        err_cnt     <= err_cnt + 17'(abs_err != '0);
        sum_abs_err <= sum_next[32] ? SUM_SAT : sum_next[31:0];
        if (abs_err > max_abs_err) max_abs_err <= abs_err;
      end
    end
  end

endmodule
